// File: rtl/if_fetch_stage_pkg.sv
// rtl/if_fetch_stage_pkg.sv - shared widths, constants and FSM encoding for the fetch stage
package if_fetch_stage_pkg;

    localparam int DATAWIDTH_DEF = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        IF_IDLE   = 3'd0,
        IF_REQ    = 3'd1,
        IF_WAIT   = 3'd2,
        IF_HOLD   = 3'd3,
        IF_CANCEL = 3'd4
    } if_state_e;

endpackage

// File: rtl/if_fetch_stage_if.sv
// rtl/if_fetch_stage_if.sv - instruction-memory and IF/ID handshake bundle (IF_ADDR_ERR_EN adds out_addr_err)
interface if_fetch_stage_if #(
    parameter int DATAWIDTH = 32
);
    logic                 inst_req;
    logic [DATAWIDTH-1:0] inst_addr;
    logic                 inst_addr_ok;
    logic                 inst_data_ok;
    logic [DATAWIDTH-1:0] inst_rdata;
    logic                 validout;
    logic                 out_allow;
    logic [DATAWIDTH-1:0] out_PC_now;
    logic [DATAWIDTH-1:0] out_PC_add_4;
    logic [DATAWIDTH-1:0] out_instr;
`ifdef IF_ADDR_ERR_EN
    logic                 out_addr_err;

    modport master (
        output inst_req, inst_addr, validout, out_PC_now, out_PC_add_4, out_instr, out_addr_err,
        input  inst_addr_ok, inst_data_ok, inst_rdata, out_allow
    );
    modport slave (
        input  inst_req, inst_addr, validout, out_PC_now, out_PC_add_4, out_instr, out_addr_err,
        output inst_addr_ok, inst_data_ok, inst_rdata, out_allow
    );
`else
    modport master (
        output inst_req, inst_addr, validout, out_PC_now, out_PC_add_4, out_instr,
        input  inst_addr_ok, inst_data_ok, inst_rdata, out_allow
    );
    modport slave (
        input  inst_req, inst_addr, validout, out_PC_now, out_PC_add_4, out_instr,
        output inst_addr_ok, inst_data_ok, inst_rdata, out_allow
    );
`endif
endinterface

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - PC owner and single-outstanding instruction fetch; IF_ADDR_ERR_EN enables misaligned-PC reporting
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter int                   DATAWIDTH = DATAWIDTH_DEF,
    parameter logic [DATAWIDTH-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 br_taken,
    input  logic [DATAWIDTH-1:0] br_target,
    if_fetch_stage_if.master     fb
);

    if_state_e            state_q, state_d;
    logic [DATAWIDTH-1:0] fetch_pc;
    logic [DATAWIDTH-1:0] req_pc;
    logic [DATAWIDTH-1:0] pc_now_q;
    logic [DATAWIDTH-1:0] pc_add4_q;
    logic [DATAWIDTH-1:0] instr_q;
    logic                 hold_valid;
    logic [DATAWIDTH-1:0] redirect_pc;
    logic                 misaligned;
    logic                 accept;
    logic                 transfer;
    logic                 data_ok;

`ifdef IF_ADDR_ERR_EN
    logic addr_err_q;
    assign redirect_pc     = br_target;
    assign misaligned      = |fetch_pc[1:0];
    assign fb.out_addr_err = addr_err_q;
`else
    assign redirect_pc = br_target & ~DATAWIDTH'(3);
    assign misaligned  = 1'b0;
`endif

    assign data_ok  = fb.inst_data_ok;
    assign accept   = fb.inst_req & fb.inst_addr_ok;
    assign transfer = fb.validout & fb.out_allow;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IF_IDLE;
        else        state_q <= state_d;
    end

    // Redirect outranks everything; a response already in flight is discarded via CANCEL.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IF_IDLE:   state_d = IF_REQ;
            IF_REQ: begin
                if (br_taken)        state_d = accept ? IF_CANCEL : IF_REQ;
                else if (misaligned) state_d = IF_HOLD;
                else if (accept)     state_d = IF_WAIT;
            end
            IF_WAIT: begin
                if (br_taken)     state_d = data_ok ? IF_REQ : IF_CANCEL;
                else if (data_ok) state_d = IF_HOLD;
            end
            IF_HOLD: begin
                if (br_taken || transfer) state_d = IF_REQ;
            end
            IF_CANCEL: begin
                if (data_ok) state_d = IF_REQ;
            end
            default:   state_d = IF_IDLE;
        endcase
    end

    always_comb begin
        fb.inst_req     = (state_q == IF_REQ) && !misaligned;
        fb.inst_addr    = fetch_pc;
        fb.validout     = hold_valid && !br_taken;
        fb.out_PC_now   = pc_now_q;
        fb.out_PC_add_4 = pc_add4_q;
        fb.out_instr    = instr_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc   <= RESET_PC;
            req_pc     <= '0;
            pc_now_q   <= '0;
            pc_add4_q  <= '0;
            instr_q    <= '0;
            hold_valid <= 1'b0;
`ifdef IF_ADDR_ERR_EN
            addr_err_q <= 1'b0;
`endif
        end else if (br_taken) begin
            fetch_pc   <= redirect_pc;
            hold_valid <= 1'b0;
        end else begin
`ifdef IF_ADDR_ERR_EN
            if (state_q == IF_REQ && misaligned) begin
                instr_q    <= DATAWIDTH'(NOP_INSTR);
                pc_now_q   <= fetch_pc;
                pc_add4_q  <= fetch_pc + DATAWIDTH'(4);
                addr_err_q <= 1'b1;
                hold_valid <= 1'b1;
            end
`endif
            if (accept) req_pc <= fetch_pc;
            if (state_q == IF_WAIT && data_ok) begin
                instr_q    <= fb.inst_rdata;
                pc_now_q   <= req_pc;
                pc_add4_q  <= req_pc + DATAWIDTH'(4);
                hold_valid <= 1'b1;
`ifdef IF_ADDR_ERR_EN
                addr_err_q <= 1'b0;
`endif
            end
            if (transfer) begin
                hold_valid <= 1'b0;
                fetch_pc   <= pc_now_q + DATAWIDTH'(4);
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - directed and randomized bench for if_fetch_stage against an expected-PC-stream model
module tb_if_fetch_stage;
    import if_fetch_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = '0;

    if_fetch_stage_if #(.DATAWIDTH(32)) fb();

    if_fetch_stage #(.DATAWIDTH(32), .RESET_PC(32'h0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .br_taken  (br_taken),
        .br_target (br_target),
        .fb        (fb.master)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_pc;
    int          n_xfer = 0;
    int          acc_cnt = 0;
    logic [31:0] acc_addr;
    logic [31:0] last_x_pc, last_x_add4, last_x_instr;
    bit          s_accept, s_xfer, s_data_ok;
    bit          prev_stall;
    logic [31:0] prev_pc, prev_add4, prev_instr;
    bit          mem_busy;
    logic [31:0] mem_addr;
    int          mem_cnt;
    logic [31:0] mem_xor;
    int          mem_dly_min, mem_dly_max, addr_ok_pct;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] redirect_of(input logic [31:0] t);
`ifdef IF_ADDR_ERR_EN
        return t;
`else
        return t & ~32'd3;
`endif
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        br_taken = 1'b0;
        fb.out_allow = 1'b0;
        fb.inst_addr_ok = 1'b0;
        fb.inst_data_ok = 1'b0;
        fb.inst_rdata = '0;
        mem_busy = 1'b0;
        @(negedge clk);
        check_eq("rst_inst_req", fb.inst_req, 0);
        check_eq("rst_validout", fb.validout, 0);
        check_eq("rst_pc_now", fb.out_PC_now, 0);
        check_eq("rst_pc_add4", fb.out_PC_add_4, 0);
        check_eq("rst_instr", fb.out_instr, 0);
`ifdef IF_ADDR_ERR_EN
        check_eq("rst_addr_err", fb.out_addr_err, 0);
`endif
        rst_n = 1'b1;
        exp_pc = 32'h0;
        prev_stall = 1'b0;
    endtask

    // One clock: drive memory/branch/allow, sample, then advance the model as the posedge will.
    task automatic step(input bit br, input logic [31:0] tgt, input bit allow);
        bit exp_err;
        @(negedge clk);
        s_data_ok = 1'b0;
        fb.inst_data_ok = 1'b0;
        if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                fb.inst_data_ok = 1'b1;
                fb.inst_rdata = mem_addr ^ mem_xor;
                mem_busy = 1'b0;
                s_data_ok = 1'b1;
            end
        end
        br_taken = br;
        br_target = tgt;
        fb.out_allow = allow;
        fb.inst_addr_ok = fb.inst_req && !mem_busy && ($urandom_range(0, 99) < addr_ok_pct);
        #1;
        s_accept = fb.inst_req && fb.inst_addr_ok;
        s_xfer = fb.validout && allow;
        if (br) check_eq("valid_on_redirect", fb.validout, 0);
        if (prev_stall && !br) begin
            check_eq("stall_valid", fb.validout, 1);
            check_eq("stall_pc", fb.out_PC_now, prev_pc);
            check_eq("stall_add4", fb.out_PC_add_4, prev_add4);
            check_eq("stall_instr", fb.out_instr, prev_instr);
        end
        if (s_xfer) begin
            exp_err = (exp_pc[1:0] != 2'b00);
            check_eq("xfer_pc", fb.out_PC_now, exp_pc);
            check_eq("xfer_add4", fb.out_PC_add_4, exp_pc + 32'd4);
            check_eq("xfer_instr", fb.out_instr, exp_err ? NOP_INSTR : (exp_pc ^ mem_xor));
`ifdef IF_ADDR_ERR_EN
            check_eq("xfer_addr_err", fb.out_addr_err, exp_err);
`endif
            last_x_pc = fb.out_PC_now;
            last_x_add4 = fb.out_PC_add_4;
            last_x_instr = fb.out_instr;
            exp_pc = exp_pc + 32'd4;
            n_xfer++;
        end
        if (br) exp_pc = redirect_of(tgt);
        prev_stall = fb.validout && !allow;
        prev_pc = fb.out_PC_now;
        prev_add4 = fb.out_PC_add_4;
        prev_instr = fb.out_instr;
        if (s_accept) begin
            mem_busy = 1'b1;
            mem_addr = fb.inst_addr;
            mem_cnt = $urandom_range(mem_dly_min, mem_dly_max);
            acc_addr = fb.inst_addr;
            acc_cnt++;
        end
    endtask

    task automatic wait_accept(input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            step(1'b0, 32'h0, 1'b1);
            got = s_accept;
        end
        if (!got) check_eq(tag, 0, 1);
    endtask

    task automatic wait_xfer(input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            step(1'b0, 32'h0, 1'b1);
            got = s_xfer;
        end
        if (!got) check_eq(tag, 0, 1);
    endtask

    initial begin
        int base_x;
        int base_acc;
        bit seen_data;
        bit got;
        bit br;
        logic [31:0] tgt;

        addr_ok_pct = 100;
        mem_dly_min = 1;
        mem_dly_max = 1;
        mem_xor = 32'h0;
        do_reset();

        // Zero-wait memory returning the address as data: validout every third cycle.
        for (int k = 1; k <= 6; k++) begin
            step(1'b0, 32'h0, 1'b1);
            check_eq($sformatf("t1_valid_c%0d", k), fb.validout, (k % 3 == 0));
            if (k == 1) begin
                check_eq("t1_req", fb.inst_req, 1);
                check_eq("t1_req_addr", fb.inst_addr, 32'h0);
            end
            if (k == 3) begin
                check_eq("t1_pc0", fb.out_PC_now, 32'h0);
                check_eq("t1_add4", fb.out_PC_add_4, 32'h4);
            end
            if (k == 6) check_eq("t1_pc4", fb.out_PC_now, 32'h4);
        end
        check_eq("t1_xfers", n_xfer, 2);

        // Back-pressure in HOLD.
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step(1'b0, 32'h0, 1'b0);
            got = fb.validout;
        end
        check_eq("t2_reach_hold", got, 1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 32'h0, 1'b0);
            check_eq("t2_hold_valid", fb.validout, 1);
            check_eq("t2_hold_noreq", fb.inst_req, 0);
        end
        base_x = n_xfer;
        step(1'b0, 32'h0, 1'b1);
        check_eq("t2_release_xfer", s_xfer, 1);
        step(1'b0, 32'h0, 1'b1);
        check_eq("t2_single_xfer", fb.validout, 0);
        check_eq("t2_xfer_count", n_xfer - base_x, 1);

        // Redirect in WAIT with a slow response: stale word must be discarded.
        mem_dly_min = 3;
        mem_dly_max = 3;
        wait_accept("t3_tmo_accept");
        step(1'b1, 32'h100, 1'b1);
        seen_data = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step(1'b0, 32'h0, 1'b1);
            if (!seen_data && !s_data_ok) check_eq("t3_no_req_in_cancel", fb.inst_req, 0);
            if (s_data_ok) seen_data = 1'b1;
            got = s_accept;
        end
        check_eq("t3_tmo_req", got, 1);
        check_eq("t3_req_addr", acc_addr, 32'h100);
        wait_xfer("t3_tmo_xfer");
        check_eq("t3_xfer_pc", last_x_pc, 32'h100);

        // Redirect while holding with out_allow=1: no transfer that cycle.
        mem_dly_min = 1;
        mem_dly_max = 1;
        wait_accept("t4_tmo_accept");
        step(1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h200, 1'b1);
        check_eq("t4_no_xfer", s_xfer, 0);
        wait_accept("t4_tmo_accept2");
        check_eq("t4_req_addr", acc_addr, 32'h200);
        wait_xfer("t4_tmo_xfer");

        // Two redirects while cancelling: the last one wins.
        mem_dly_min = 4;
        mem_dly_max = 4;
        wait_accept("t5_tmo_accept");
        step(1'b1, 32'h300, 1'b1);
        step(1'b1, 32'h400, 1'b1);
        wait_accept("t5_tmo_accept2");
        check_eq("t5_req_addr", acc_addr, 32'h400);
        wait_xfer("t5_tmo_xfer");

        // PC+4 wraps at the top of the address space.
        mem_dly_min = 1;
        mem_dly_max = 1;
        wait_accept("t7_tmo_accept");
        step(1'b0, 32'h0, 1'b1);
        step(1'b1, 32'hFFFF_FFFC, 1'b1);
        wait_xfer("t7_tmo_xfer");
        check_eq("t7_pc_top", last_x_pc, 32'hFFFF_FFFC);
        check_eq("t7_add4_wrap", last_x_add4, 32'h0);
        wait_xfer("t7_tmo_xfer2");
        check_eq("t7_pc_wrapped", last_x_pc, 32'h0);

`ifdef IF_ADDR_ERR_EN
        // Misaligned redirect target: no request, a NOP flagged with out_addr_err.
        wait_accept("t6_tmo_accept");
        step(1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h102, 1'b1);
        base_acc = acc_cnt;
        wait_xfer("t6_tmo_xfer");
        check_eq("t6_no_req", acc_cnt - base_acc, 0);
        check_eq("t6_pc", last_x_pc, 32'h102);
        check_eq("t6_instr", last_x_instr, 32'h13);
`endif

        // Randomized traffic against the expected-PC model.
        do_reset();
        mem_xor = 32'h3C3C_0000;
        addr_ok_pct = 60;
        mem_dly_min = 1;
        mem_dly_max = 4;
        base_x = n_xfer;
        for (int i = 0; i < 3000; i++) begin
            br = ($urandom_range(0, 99) < 8);
            tgt = $urandom;
`ifdef IF_ADDR_ERR_EN
            tgt = tgt & ~32'd3;
`endif
            step(br, tgt, ($urandom_range(0, 99) < 70));
        end
        check_eq("rand_progress", (n_xfer - base_x) > 50, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Fetch-side producer for the IF/ID pipeline register; drives its validin and consumes its in_allow.
- Owns the PC, issues one instruction-memory request at a time and buffers the returned word.
- Presents PC_now, PC+4 and instr with valid/allow flow control.
- Handles branch/jump redirects, including cancelling and discarding in-flight wrong-path responses.

Parameters:
- DATAWIDTH, 32, width of PC and instruction; equals `datawidth.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- br_taken  in  1  single-cycle redirect request
- br_target  in  DATAWIDTH  redirect address
- inst_req  out  1  memory request valid
- inst_addr  out  DATAWIDTH  request address
- inst_addr_ok  in  1  request accepted this cycle
- inst_data_ok  in  1  response valid this cycle
- inst_rdata  in  DATAWIDTH  response word
- validout  out  1  fetched instruction valid; wires to IF/ID validin
- out_allow  in  1  IF/ID in_allow
- out_PC_now  out  DATAWIDTH  PC of buffered instruction
- out_PC_add_4  out  DATAWIDTH  out_PC_now + 4
- out_instr  out  DATAWIDTH  buffered instruction

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE, fetch_pc=RESET_PC.
  - out_PC_now, out_PC_add_4 and out_instr all 0; hold_valid=0.
  - Outputs: inst_req=0, validout=0.
  - Reset mid-transaction abandons the outstanding request; the memory side is reset with the core.
- States: IDLE, REQ, WAIT, HOLD, CANCEL; at most one request outstanding.
- IDLE:
  - Go to REQ next cycle.
- REQ:
  - inst_req=1, inst_addr=fetch_pc.
  - On inst_addr_ok: go to WAIT and latch req_pc=fetch_pc.
- WAIT:
  - On inst_data_ok: out_instr<=inst_rdata, out_PC_now<=req_pc, out_PC_add_4<=req_pc+4.
  - Then hold_valid<=1 and go to HOLD.
- HOLD:
  - validout = hold_valid & ~br_taken.
  - On validout & out_allow (transfer): hold_valid<=0, fetch_pc<=out_PC_now+4, go to REQ.
- Throughput:
  - With a zero-wait memory (addr_ok same cycle, data_ok next cycle): one instruction per 3 cycles.
  - First validout occurs at cycle 3 after reset release.
- Arithmetic: PC+4 is modulo 2^DATAWIDTH; 32'hFFFF_FFFC wraps to 0.
- Redirect (br_taken=1) has priority over all other events; target is br_target with bits[1:0] forced to 0.
  - IDLE: fetch_pc<=target.
  - REQ, no addr_ok: fetch_pc<=target; stay in REQ. inst_addr changes while unaccepted, which is legal on this interface.
  - REQ with addr_ok same cycle: fetch_pc<=target; go to CANCEL.
  - WAIT without data_ok: fetch_pc<=target; go to CANCEL.
  - WAIT with data_ok: drop the data; fetch_pc<=target; go to REQ.
  - CANCEL: fetch_pc<=target; stay in CANCEL (last redirect wins).
  - HOLD: validout is suppressed combinationally that cycle, so no transfer occurs even if out_allow=1. hold_valid<=0; fetch_pc<=target; go to REQ.
- CANCEL:
  - inst_req=0.
  - On inst_data_ok: discard the word; go to REQ.
- Output stability: validout never drops without a transfer except on redirect. out_* are stable while validout=1 and out_allow=0.

Optional Feature:
- Macro: IF_ADDR_ERR_EN.
- With it:
  - The redirect target is not masked.
  - In REQ, if fetch_pc[1:0]!=0, no request is issued (inst_req=0).
  - Next cycle goes to HOLD with out_instr=`NOP_INSTR, out_PC_now=fetch_pc and out_addr_err=1.
  - Extra port: out_addr_err  out  1. It resets to 0 and is valid with validout.
- Without it: bits[1:0] are forced to 0 and the port is absent.

Decomposition:
- Add to defines.v:
  - FSM encodings: `IF_IDLE, `IF_REQ, `IF_WAIT, `IF_HOLD, `IF_CANCEL.
  - `NOP_INSTR=32'h0000_0013.
  - Reuse `datawidth.
- No sub-module; PC-next selection stays inline.

Test Plan:
- Reset release, zero-wait memory returning addr as data, out_allow=1 -> validout at cycle 3 with out_PC_now=0, out_PC_add_4=4; next at PC 4 three cycles later.
- out_allow=0 for 5 cycles in HOLD -> validout stays 1, out_* stable, inst_req=0; releasing gives exactly one transfer.
- br_taken target 0x100 in WAIT, data_ok delayed 2 cycles -> CANCEL; stale word never reaches validout; next inst_addr=0x100.
- br_taken target 0x200 in HOLD with out_allow=1 -> validout=0 that cycle, no transfer; next request addr 0x200.
- Two redirects 0x300 then 0x400 during CANCEL -> first request after data_ok is 0x400.
- With IF_ADDR_ERR_EN, br_target=0x102 -> no inst_req; validout=1 with out_instr=0x13, out_PC_now=0x102, out_addr_err=1.
